// File: rtl/sliced_alu_pkg.sv
// Shared definitions for the sliced ALU: operation codes, status flag codes,
// FSM state encodings and the flag-selection helper.
package sliced_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_AND    = 3'b010,
      OP_OR     = 3'b011,
      OP_XOR    = 3'b100,
      OP_NOT_A  = 3'b101,
      OP_PASS_A = 3'b110,
      OP_PASS_B = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      DEFAULT_FLAG  = 2'b00,
      ZERO_FLAG     = 2'b01,
      OVERFLOW_FLAG = 2'b10,
      NEGATIVE_FLAG = 2'b11
   } flag_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   function automatic logic is_arith(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Carry/borrow outranks zero for the arithmetic ops.
   function automatic flag_e flag_sel(input op_e op, input logic cb, input logic zero);
      flag_e f;
      f = DEFAULT_FLAG;
      case (op)
         OP_ADD:  f = cb ? OVERFLOW_FLAG : (zero ? ZERO_FLAG : DEFAULT_FLAG);
         OP_SUB:  f = cb ? NEGATIVE_FLAG : (zero ? ZERO_FLAG : DEFAULT_FLAG);
         default: f = zero ? ZERO_FLAG : DEFAULT_FLAG;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/sliced_alu_slice.sv
// alu_slice: combinational SLICE_WIDTH-bit ALU slice.
// Ports:
//   a_i, b_i  slice operands
//   op_i      operation code
//   c_i       carry-in (ADD) / borrow-in (SUB)
//   y_o       slice result
//   c_o       carry-out (ADD) / borrow-out (SUB), 0 for logic ops
module alu_slice
   import sliced_alu_pkg::*;
#(
   parameter int SLICE_WIDTH = 4
) (
   input  logic [SLICE_WIDTH-1:0] a_i,
   input  logic [SLICE_WIDTH-1:0] b_i,
   input  op_e                    op_i,
   input  logic                   c_i,
   output logic [SLICE_WIDTH-1:0] y_o,
   output logic                   c_o
);

   logic [SLICE_WIDTH:0] sum;
   logic [SLICE_WIDTH:0] diff;

   // The extra top bit of the widened difference is the borrow out.
   assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_WIDTH{1'b0}}, c_i};
   assign diff = {1'b0, a_i} - {1'b0, b_i} - {{SLICE_WIDTH{1'b0}}, c_i};

   always_comb begin
      y_o = '0;
      c_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            y_o = sum[SLICE_WIDTH-1:0];
            c_o = sum[SLICE_WIDTH];
         end
         OP_SUB: begin
            y_o = diff[SLICE_WIDTH-1:0];
            c_o = diff[SLICE_WIDTH];
         end
         OP_AND:    y_o = a_i & b_i;
         OP_OR:     y_o = a_i | b_i;
         OP_XOR:    y_o = a_i ^ b_i;
         OP_NOT_A:  y_o = ~a_i;
         OP_PASS_A: y_o = a_i;
         OP_PASS_B: y_o = b_i;
         default: begin
            y_o = '0;
            c_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sliced_alu.sv
// sliced_alu: multi-cycle ALU that walks WIDTH-bit operands through a
// SLICE_WIDTH-bit datapath, LSB slice first, one slice per clock. A stored
// carry/borrow and zero state allow chained multi-precision ADD/SUB.
// Ports:
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   in_valid_i / in_ready_o            operand handshake
//   a_i, b_i, op_i                     operands and operation
//   carry_borrow_i, chain_i            carry/borrow-in, or use stored state
//   out_valid_o / out_ready_i          result handshake
//   y_o, carry_borrow_o, status_flag_o result, final carry/borrow, flag code
//
// state | meaning
// IDLE  | ready for operands; accept latches operands and cin
// RUN   | one slice per cycle, carry/borrow registered between slices
// DONE  | result valid and held until out_ready_i
module sliced_alu
   import sliced_alu_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int SLICE_WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   input  logic             carry_borrow_i,
   input  logic             chain_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] y_o,
   output logic             carry_borrow_o,
   output logic [1:0]       status_flag_o
);

   localparam int NSLICES = WIDTH / SLICE_WIDTH;
   localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

   if ((SLICE_WIDTH < 1) || ((WIDTH % SLICE_WIDTH) != 0)) begin : g_bad_width
      $error("sliced_alu: WIDTH must be a non-zero multiple of SLICE_WIDTH");
   end

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   op_e              op_q, op_d;
   logic             chain_q, chain_d;
   logic             cb_q, cb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nz_q, nz_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             cb_out_q, cb_out_d;
   flag_e            flag_q, flag_d;
   logic             st_cb_q, st_cb_d;
   logic             st_zero_q, st_zero_d;

   logic                   load;
   logic                   step;
   logic                   last_slice;
   logic [SLICE_WIDTH-1:0] sl_y;
   logic                   sl_c;
   logic [WIDTH-1:0]       y_shift;
   logic [WIDTH-1:0]       a_shift;
   logic [WIDTH-1:0]       b_shift;
   logic                   zero_fin;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      step        = 1'b0;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign last_slice = step && (cnt_q == LAST_CNT);

   // ------------------------------------------------------------------
   // Slice datapath: the current slice always sits in the low bits of the
   // operand shift registers; results enter the result register from the
   // top so that after NSLICES steps the LSB slice has reached bit 0.
   // ------------------------------------------------------------------
   alu_slice #(
      .SLICE_WIDTH(SLICE_WIDTH)
   ) u_slice (
      .a_i  (a_q[SLICE_WIDTH-1:0]),
      .b_i  (b_q[SLICE_WIDTH-1:0]),
      .op_i (op_q),
      .c_i  (cb_q),
      .y_o  (sl_y),
      .c_o  (sl_c)
   );

   if (NSLICES == 1) begin : g_single
      assign y_shift = sl_y;
      assign a_shift = '0;
      assign b_shift = '0;
   end else begin : g_multi
      assign y_shift = {sl_y, y_q[WIDTH-1:SLICE_WIDTH]};
      assign a_shift = {{SLICE_WIDTH{1'b0}}, a_q[WIDTH-1:SLICE_WIDTH]};
      assign b_shift = {{SLICE_WIDTH{1'b0}}, b_q[WIDTH-1:SLICE_WIDTH]};
   end

   // Chained arithmetic is only zero if every earlier word was zero too.
   assign zero_fin = !(nz_q || (|sl_y)) &&
                     (!(chain_q && is_arith(op_q)) || st_zero_q);

   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      chain_d   = chain_q;
      cb_d      = cb_q;
      cnt_d     = cnt_q;
      nz_d      = nz_q;
      y_d       = y_q;
      cb_out_d  = cb_out_q;
      flag_d    = flag_q;
      st_cb_d   = st_cb_q;
      st_zero_d = st_zero_q;
      if (load) begin
         a_d     = a_i;
         b_d     = b_i;
         op_d    = op_e'(op_i);
         chain_d = chain_i;
         cb_d    = chain_i ? st_cb_q : carry_borrow_i;
         cnt_d   = '0;
         nz_d    = 1'b0;
      end else if (step) begin
         a_d   = a_shift;
         b_d   = b_shift;
         cb_d  = sl_c;
         y_d   = y_shift;
         nz_d  = nz_q | (|sl_y);
         cnt_d = cnt_q + 1'b1;
         if (last_slice) begin
            cb_out_d = sl_c;
            flag_d   = flag_sel(op_q, sl_c, zero_fin);
            if (is_arith(op_q)) begin
               st_cb_d   = sl_c;
               st_zero_d = zero_fin;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         chain_q   <= 1'b0;
         cb_q      <= 1'b0;
         cnt_q     <= '0;
         nz_q      <= 1'b0;
         y_q       <= '0;
         cb_out_q  <= 1'b0;
         flag_q    <= DEFAULT_FLAG;
         st_cb_q   <= 1'b0;
         st_zero_q <= 1'b1;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         chain_q   <= chain_d;
         cb_q      <= cb_d;
         cnt_q     <= cnt_d;
         nz_q      <= nz_d;
         y_q       <= y_d;
         cb_out_q  <= cb_out_d;
         flag_q    <= flag_d;
         st_cb_q   <= st_cb_d;
         st_zero_q <= st_zero_d;
      end
   end

   assign y_o            = y_q;
   assign carry_borrow_o = cb_out_q;
   assign status_flag_o  = flag_q;

endmodule

// File: doc/sliced_alu.md
Name: sliced_alu

Overview:
Parametrised, multi-cycle successor to the 8-bit ripple ALU. It processes WIDTH-bit operands through a SLICE_WIDTH-bit datapath, LSB slice first, one slice per clock, and registers the carry/borrow between slices. A stored carry/borrow and zero state let consecutive ops chain into multi-precision arithmetic. Operands and results use valid/ready handshakes so the block sits between the operand register file and the result/status writeback.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE_WIDTH, otherwise elaboration fails.
SLICE_WIDTH, 4, bits processed per cycle; SLICE_WIDTH == WIDTH gives a single-cycle RUN.

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, synchronous, active-low
in_valid_i  input  1  operand bundle valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  operand A
b_i  input  WIDTH  operand B
op_i  input  3  operation code
carry_borrow_i  input  1  carry-in (ADD) or borrow-in (SUB) when chain_i=0
chain_i  input  1  use stored carry/borrow and stored zero instead of carry_borrow_i
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
y_o  output  WIDTH  result
carry_borrow_o  output  1  final carry (ADD) or borrow (SUB); 0 for logic ops
status_flag_o  output  2  DEFAULT/ZERO/OVERFLOW/NEGATIVE flag code

Behaviour:
- One clock; reset is synchronous and active-low (rst_ni sampled on the clk_i rising edge).
- Ops: ADD 000 = A+B+cin; SUB 001 = A-B-bin; AND 010; OR 011; XOR 100; NOT_A 101; PASS_A 110; PASS_B 111.
- States: IDLE, RUN, DONE.
- IDLE: in_ready_o=1. When in_valid_i=1, latch a, b, op, chain and cin. cin = stored carry/borrow if chain_i, else carry_borrow_i. Clear the slice counter and go to RUN.
- RUN: each cycle computes slice k (bits k*SLICE_WIDTH upward) with the registered carry/borrow. The result goes into the result register, the carry/borrow register updates, and a running OR of nonzero result bits accumulates. After slice NSLICES-1 (NSLICES = WIDTH/SLICE_WIDTH), go to DONE.
- Latency: operands accepted at edge T, out_valid_o=1 after edge T+NSLICES.
- DONE: out_valid_o=1. y_o, carry_borrow_o and status_flag_o are held stable until out_ready_i=1, then go to IDLE. in_ready_o=0 in RUN and DONE; in_valid_i is ignored there.
- Carry/borrow: ADD carry out of the MSB; SUB borrow out of the MSB (1 means the unsigned result is negative); logic ops give 0.
- zero = result == 0. For chained ADD/SUB, zero = (result == 0) AND stored_zero.
- Flag priority:
  - ADD: carry → OVERFLOW_FLAG, else zero → ZERO_FLAG, else DEFAULT_FLAG.
  - SUB: borrow → NEGATIVE_FLAG, else zero → ZERO_FLAG, else DEFAULT_FLAG.
  - Logic ops: zero → ZERO_FLAG, else DEFAULT_FLAG.
- Stored state: updated at entry to DONE for ADD/SUB only; stored carry/borrow = carry_borrow_o, stored_zero = zero. Logic ops leave stored state unchanged.
- Reset (rst_ni=0 at any edge, including mid-RUN or in DONE): state=IDLE, y_o=0, carry_borrow_o=0, status_flag_o=DEFAULT_FLAG, out_valid_o=0, slice counter=0, stored carry=0, stored_zero=1. in_ready_o=1 on the first cycle after reset is released. Any in-flight op is discarded.

Decomposition:
- Shared constants header: op codes (3-bit), status flag codes DEFAULT/ZERO/OVERFLOW/NEGATIVE_FLAG (2-bit), FSM state encodings.
- One combinational sub-module, alu_slice (parameter SLICE_WIDTH). Inputs: slice operands, op, carry-in. Outputs: slice result, carry-out.
- Top level holds the FSM, counter, registers and flag logic.

Test Plan:
- WIDTH=16, SLICE=4: ADD 0x1234+0x0FCC, cin=0 → y=0x2200, carry=0, DEFAULT_FLAG; out_valid_o rises exactly 4 cycles after accept.
- ADD 0xFFFF+0x0001 → y=0x0000, carry=1, OVERFLOW_FLAG (carry beats zero). Then chained ADD 0x0000+0x0000 → y=0x0001, carry=0, DEFAULT_FLAG.
- SUB 0x0005-0x0007 → y=0xFFFE, borrow=1, NEGATIVE_FLAG. Then chained SUB 0x0001-0x0000 → y=0x0000, borrow=0, DEFAULT_FLAG (stored_zero=0). XOR 0xA5A5^0xA5A5 → 0x0000, ZERO_FLAG, carry_borrow_o=0.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE while toggling in_valid_i → outputs stable, in_ready_o=0, no operand accepted.
- Reset low for one edge during slice 2 of an ADD → next cycle IDLE, out_valid_o=0, in_ready_o=1. A following chained ADD 0x0001+0x0001 gives 0x0002 (stored carry cleared).
- SLICE_WIDTH=WIDTH=8: ADD 0x80+0x80 → y=0x00, carry=1, OVERFLOW_FLAG, out_valid_o 1 cycle after accept.
